// File: rtl/alu_pkg.sv
// Shared definitions for the RV32I execute block.
//  - opcode / funct3 encodings
//  - alu_op_e: internal ALU operation select
//  - exec_result_t: the out_* bundle carried through the output register
// The struct is sized by PKG_XLEN / PKG_NREGS. The top-level XLEN / NREGS
// parameters must match these constants; change both together when widening.
package alu_pkg;

  localparam int PKG_XLEN  = 32;
  localparam int PKG_NREGS = 32;
  localparam int PKG_RW    = $clog2(PKG_NREGS);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;

  typedef struct packed {
    logic [PKG_XLEN-1:0] result;
    logic [PKG_RW-1:0]   rd;
    logic                we;
    logic                mem_rd;
    logic                mem_wr;
    logic [PKG_XLEN-1:0] mem_addr;
    logic [PKG_XLEN-1:0] store_data;
    logic                branch;
    logic [PKG_XLEN-1:0] target;
    logic                illegal;
  } exec_result_t;

endpackage

// File: rtl/alu_core.sv
// Combinational RV32I execute: resolved operands + pc + decode -> exec_result_t.
// Ports:
//  opcode, funct3, funct7_b5  decode fields (funct7_b5 selects SUB / SRA)
//  alu_src                    1 = operand B is imm
//  rd_idx                     destination, passed through
//  rs1_val, rs2_val           resolved source operands
//  imm, pc                    immediate and instruction pc
//  res                        full result bundle
module alu_core
  import alu_pkg::*;
(
  input  logic [6:0]          opcode,
  input  logic [2:0]          funct3,
  input  logic                funct7_b5,
  input  logic                alu_src,
  input  logic [PKG_RW-1:0]   rd_idx,
  input  logic [PKG_XLEN-1:0] rs1_val,
  input  logic [PKG_XLEN-1:0] rs2_val,
  input  logic [PKG_XLEN-1:0] imm,
  input  logic [PKG_XLEN-1:0] pc,
  output exec_result_t        res
);

  localparam int XLEN = PKG_XLEN;
  localparam int SHW  = $clog2(XLEN);

  logic [XLEN-1:0] b, alu_y, ea;
  logic [SHW-1:0]  shamt;
  alu_op_e         op;
  logic            br_take;

  assign b     = alu_src ? imm : rs2_val;
  assign shamt = b[SHW-1:0];
  assign ea    = rs1_val + imm;

  // SUB exists only in register-register form; SRA/SRAI share funct7[5].
  always_comb begin
    op = ALU_ADD;
    case (funct3)
      F3_ADD:  op = (opcode == OPC_OP && funct7_b5) ? ALU_SUB : ALU_ADD;
      F3_SLL:  op = ALU_SLL;
      F3_SLT:  op = ALU_SLT;
      F3_SLTU: op = ALU_SLTU;
      F3_XOR:  op = ALU_XOR;
      F3_SR:   op = funct7_b5 ? ALU_SRA : ALU_SRL;
      F3_OR:   op = ALU_OR;
      default: op = ALU_AND;
    endcase
  end

  always_comb begin
    alu_y = '0;
    case (op)
      ALU_ADD:  alu_y = rs1_val + b;
      ALU_SUB:  alu_y = rs1_val - b;
      ALU_SLL:  alu_y = rs1_val << shamt;
      ALU_SLT:  alu_y = {{(XLEN-1){1'b0}}, $signed(rs1_val) < $signed(b)};
      ALU_SLTU: alu_y = {{(XLEN-1){1'b0}}, rs1_val < b};
      ALU_XOR:  alu_y = rs1_val ^ b;
      ALU_SRL:  alu_y = rs1_val >> shamt;
      ALU_SRA:  alu_y = $unsigned($signed(rs1_val) >>> shamt);
      ALU_OR:   alu_y = rs1_val | b;
      ALU_AND:  alu_y = rs1_val & b;
      default:  alu_y = '0;
    endcase
  end

  // Branches always compare rs1 against rs2, independent of alu_src.
  always_comb begin
    br_take = 1'b0;
    case (funct3)
      F3_BEQ:  br_take = (rs1_val == rs2_val);
      F3_BNE:  br_take = (rs1_val != rs2_val);
      F3_BLT:  br_take = ($signed(rs1_val) <  $signed(rs2_val));
      F3_BGE:  br_take = ($signed(rs1_val) >= $signed(rs2_val));
      F3_BLTU: br_take = (rs1_val <  rs2_val);
      F3_BGEU: br_take = (rs1_val >= rs2_val);
      default: br_take = 1'b0;
    endcase
  end

  // Anything not decoded leaves the bundle zero apart from illegal.
  always_comb begin
    res    = '0;
    res.rd = rd_idx;
    case (opcode)
      OPC_OP, OPC_OP_IMM: begin
        res.result = alu_y;
        res.we     = 1'b1;
      end
      OPC_LOAD: begin
        if (funct3 == 3'b011 || funct3[2:1] == 2'b11) res.illegal = 1'b1;
        else begin
          res.mem_rd   = 1'b1;
          res.mem_addr = ea;
          res.we       = 1'b1;
        end
      end
      OPC_STORE: begin
        if (funct3[2] || funct3 == 3'b011) res.illegal = 1'b1;
        else begin
          res.mem_wr     = 1'b1;
          res.mem_addr   = ea;
          res.store_data = rs2_val;
        end
      end
      OPC_BRANCH: begin
        if (funct3[2:1] == 2'b01) res.illegal = 1'b1;
        else begin
          res.branch = br_take;
          res.target = pc + imm;
        end
      end
      OPC_JAL: begin
        res.branch = 1'b1;
        res.target = pc + imm;
        res.result = pc + XLEN'(4);
        res.we     = 1'b1;
      end
      OPC_JALR: begin
        if (funct3 != 3'b000) res.illegal = 1'b1;
        else begin
          res.branch = 1'b1;
          res.target = {ea[XLEN-1:1], 1'b0};
          res.result = pc + XLEN'(4);
          res.we     = 1'b1;
        end
      end
      OPC_LUI: begin
        res.result = imm << 12;
        res.we     = 1'b1;
      end
      OPC_AUIPC: begin
        res.result = pc + (imm << 12);
        res.we     = 1'b1;
      end
      default: res.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_regfile_pipe.sv
// RV32I execute stage: register file, forwarding operand muxes, alu_core and
// one valid/ready output register. The held instruction writes back into the
// register file on the edge it retires.
// Ports:
//  clk, rst                      clock / async active-high reset
//  in_valid, in_ready            upstream handshake
//  in_opcode..in_pc              decoded instruction
//  out_valid, out_ready          downstream handshake
//  out_result..out_illegal       held result bundle
// XLEN / NREGS must equal alu_pkg::PKG_XLEN / PKG_NREGS (struct sizing).
module alu_regfile_pipe
  import alu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter bit BYPASS = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [6:0]               in_opcode,
  input  logic [2:0]               in_funct3,
  input  logic [6:0]               in_funct7,
  input  logic [$clog2(NREGS)-1:0] in_rs1,
  input  logic [$clog2(NREGS)-1:0] in_rs2,
  input  logic [$clog2(NREGS)-1:0] in_rd,
  input  logic [XLEN-1:0]          in_imm,
  input  logic                     in_alu_src,
  input  logic [XLEN-1:0]          in_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_result,
  output logic [$clog2(NREGS)-1:0] out_rd,
  output logic                     out_we,
  output logic                     out_mem_rd,
  output logic                     out_mem_wr,
  output logic [XLEN-1:0]          out_mem_addr,
  output logic [XLEN-1:0]          out_store_data,
  output logic                     out_branch,
  output logic [XLEN-1:0]          out_target,
  output logic                     out_illegal
);

  logic [NREGS-1:0][XLEN-1:0] rf;
  exec_result_t               res, out_q;
  logic                       out_valid_q;
  logic                       accept, retire, raw;
  logic                       fwd1, fwd2;
  logic [XLEN-1:0]            rs1_val, rs2_val;
  logic                       unused_funct7;

  // Only funct7[5] carries meaning for the supported subset.
  assign unused_funct7 = ^{in_funct7[6], in_funct7[4:0]};

  assign accept = in_valid & in_ready;
  assign retire = out_valid_q & out_ready;

  // Held result that a source would need; rd=0 never counts.
  assign raw = out_valid_q && out_q.we && out_q.rd != '0 &&
               (out_q.rd == in_rs1 || out_q.rd == in_rs2);

  // Without forwarding, wait until the producer has retired into rf.
  assign in_ready = (!out_valid_q || out_ready) && (BYPASS || !raw);

  assign fwd1 = BYPASS && out_valid_q && out_q.we && out_q.rd == in_rs1;
  assign fwd2 = BYPASS && out_valid_q && out_q.we && out_q.rd == in_rs2;

  assign rs1_val = (in_rs1 == '0) ? '0 : fwd1 ? out_q.result : rf[in_rs1];
  assign rs2_val = (in_rs2 == '0) ? '0 : fwd2 ? out_q.result : rf[in_rs2];

  alu_core u_alu (
    .opcode    (in_opcode),
    .funct3    (in_funct3),
    .funct7_b5 (in_funct7[5]),
    .alu_src   (in_alu_src),
    .rd_idx    (in_rd),
    .rs1_val   (rs1_val),
    .rs2_val   (rs2_val),
    .imm       (in_imm),
    .pc        (in_pc),
    .res       (res)
  );

  // Retire write-back and accept can share an edge: the new instruction read
  // its operands through the forward path, so both updates are consistent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
      rf          <= '0;
    end else begin
      if (retire && out_q.we && out_q.rd != '0)
        rf[out_q.rd] <= out_q.result;
      if (accept) begin
        out_valid_q <= 1'b1;
        out_q       <= res;
      end else if (retire) begin
        out_valid_q <= 1'b0;
        out_q       <= '0;
      end
    end
  end

  assign out_valid      = out_valid_q;
  assign out_result     = out_q.result;
  assign out_rd         = out_q.rd;
  assign out_we         = out_q.we;
  assign out_mem_rd     = out_q.mem_rd;
  assign out_mem_wr     = out_q.mem_wr;
  assign out_mem_addr   = out_q.mem_addr;
  assign out_store_data = out_q.store_data;
  assign out_branch     = out_q.branch;
  assign out_target     = out_q.target;
  assign out_illegal    = out_q.illegal;

endmodule

// File: tb/tb_alu_regfile_pipe.sv
module tb_alu_regfile_pipe;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid, in_valid2, out_ready, out_ready2;
  logic [6:0]  in_opcode, in_funct7;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic [31:0] in_imm, in_pc;
  logic        in_alu_src;

  logic        in_ready, out_valid, out_we, out_mem_rd, out_mem_wr, out_branch, out_illegal;
  logic [4:0]  out_rd;
  logic [31:0] out_result, out_mem_addr, out_store_data, out_target;

  logic        in_ready2, out_valid2, out_we2, out_mem_rd2, out_mem_wr2, out_branch2, out_illegal2;
  logic [4:0]  out_rd2;
  logic [31:0] out_result2, out_mem_addr2, out_store_data2, out_target2;

  logic [138:0] outs_all;
  int vectors = 0;
  int miscompares = 0;

  alu_regfile_pipe #(.XLEN(32), .NREGS(32), .BYPASS(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_imm(in_imm),
    .in_alu_src(in_alu_src), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd), .out_we(out_we), .out_mem_rd(out_mem_rd),
    .out_mem_wr(out_mem_wr), .out_mem_addr(out_mem_addr), .out_store_data(out_store_data),
    .out_branch(out_branch), .out_target(out_target), .out_illegal(out_illegal)
  );

  alu_regfile_pipe #(.XLEN(32), .NREGS(32), .BYPASS(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_imm(in_imm),
    .in_alu_src(in_alu_src), .in_pc(in_pc), .out_valid(out_valid2), .out_ready(out_ready2),
    .out_result(out_result2), .out_rd(out_rd2), .out_we(out_we2), .out_mem_rd(out_mem_rd2),
    .out_mem_wr(out_mem_wr2), .out_mem_addr(out_mem_addr2), .out_store_data(out_store_data2),
    .out_branch(out_branch2), .out_target(out_target2), .out_illegal(out_illegal2)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                     input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                     input logic [31:0] imm, input logic src, input logic [31:0] pc);
    in_opcode = op; in_funct3 = f3; in_funct7 = f7; in_rs1 = rs1; in_rs2 = rs2;
    in_rd = rd; in_imm = imm; in_alu_src = src; in_pc = pc;
  endtask

  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic [31:0] imm, input logic src, input logic [31:0] pc);
    set(op, f3, f7, rs1, rs2, rd, imm, src, pc);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_valid2 = 1'b0; out_ready = 1'b1; out_ready2 = 1'b1;
    set(7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 32'd0);
    tick(); tick();
    outs_all = {out_valid, out_we, out_mem_rd, out_mem_wr, out_branch, out_illegal, out_rd,
                out_result, out_mem_addr, out_store_data, out_target};
    vectors++; if (outs_all !== '0) begin miscompares++; $display("FAIL reset_outs got %h exp 0", outs_all); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    rst = 1'b0;
    // populate x1, x2, then hold x3 and reset mid-stream
    issue(OPC_OP_IMM, F3_ADD, 7'd0, 5'd0, 5'd0, 5'd1, 32'd7, 1'b1, 32'd0);
    issue(OPC_OP_IMM, F3_ADD, 7'd0, 5'd0, 5'd0, 5'd2, 32'd3, 1'b1, 32'd0);
    issue(OPC_OP_IMM, F3_ADD, 7'd0, 5'd0, 5'd0, 5'd3, 32'd1, 1'b1, 32'd0);
    out_ready = 1'b0;
    vectors++; if (out_valid !== 1'b1 || out_result !== 32'd1) begin miscompares++; $display("FAIL pre_reset_hold got v=%b r=%h exp v=1 r=1", out_valid, out_result); end
    #2 rst = 1'b1;
    #1;
    outs_all = {out_valid, out_we, out_mem_rd, out_mem_wr, out_branch, out_illegal, out_rd,
                out_result, out_mem_addr, out_store_data, out_target};
    vectors++; if (outs_all !== '0) begin miscompares++; $display("FAIL midreset_outs got %h exp 0", outs_all); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL midreset_in_ready got %b exp 1", in_ready); end
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    for (int i = 1; i < 32; i++) begin
      issue(OPC_OP_IMM, F3_ADD, 7'd0, 5'(i), 5'd0, 5'd0, 32'd0, 1'b1, 32'd0);
      vectors++; if (out_result !== 32'd0) begin miscompares++; $display("FAIL reset_rf_x%0d got %h exp 0", i, out_result); end
    end
  endtask

  task automatic test_forward();
    issue(OPC_OP_IMM, F3_ADD, 7'd0, 5'd0, 5'd0, 5'd1, 32'd5, 1'b1, 32'd0);
    issue(OPC_OP, F3_ADD, 7'd0, 5'd1, 5'd1, 5'd2, 32'd0, 1'b0, 32'd0);
    vectors++; if (out_result !== 32'd10 || out_rd !== 5'd2 || out_we !== 1'b1) begin miscompares++; $display("FAIL fwd_add got r=%h rd=%0d we=%b exp r=a rd=2 we=1", out_result, out_rd, out_we); end
    tick();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL retire_clears got %b exp 0", out_valid); end
    issue(OPC_OP_IMM, F3_ADD, 7'd0, 5'd2, 5'd0, 5'd0, 32'd0, 1'b1, 32'd0);
    vectors++; if (out_result !== 32'd10) begin miscompares++; $display("FAIL rf_x2 got %h exp a", out_result); end
    // no-forwarding instance: one stall cycle on RAW
    set(OPC_OP_IMM, F3_ADD, 7'd0, 5'd0, 5'd0, 5'd1, 32'd5, 1'b1, 32'd0);
    in_valid2 = 1'b1; tick();
    set(OPC_OP, F3_ADD, 7'd0, 5'd1, 5'd1, 5'd2, 32'd0, 1'b0, 32'd0); #1;
    vectors++; if (in_ready2 !== 1'b0) begin miscompares++; $display("FAIL nb_raw_stall got %b exp 0", in_ready2); end
    tick();
    vectors++; if (out_valid2 !== 1'b0 || in_ready2 !== 1'b1) begin miscompares++; $display("FAIL nb_stall_release got v=%b rdy=%b exp v=0 rdy=1", out_valid2, in_ready2); end
    tick();
    vectors++; if (out_result2 !== 32'd10 || out_rd2 !== 5'd2) begin miscompares++; $display("FAIL nb_add got r=%h rd=%0d exp r=a rd=2", out_result2, out_rd2); end
    set(OPC_OP_IMM, F3_ADD, 7'd0, 5'd0, 5'd0, 5'd3, 32'd1, 1'b1, 32'd0); #1;
    vectors++; if (in_ready2 !== 1'b1) begin miscompares++; $display("FAIL nb_no_raw got %b exp 1", in_ready2); end
    tick(); in_valid2 = 1'b0;
    vectors++; if (out_result2 !== 32'd1 || out_rd2 !== 5'd3) begin miscompares++; $display("FAIL nb_addi got r=%h rd=%0d exp r=1 rd=3", out_result2, out_rd2); end
    tick();
  endtask

  task automatic test_backpressure();
    issue(OPC_OP_IMM, F3_ADD, 7'd0, 5'd0, 5'd0, 5'd3, 32'd9, 1'b1, 32'd0);
    out_ready = 1'b0;
    set(OPC_OP, F3_ADD, 7'd0, 5'd3, 5'd0, 5'd4, 32'd0, 1'b0, 32'd0);
    in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready c%0d got %b exp 0", c, in_ready); end
      vectors++; if (out_valid !== 1'b1 || out_result !== 32'd9 || out_rd !== 5'd3) begin miscompares++; $display("FAIL bp_hold c%0d got v=%b r=%h rd=%0d exp v=1 r=9 rd=3", c, out_valid, out_result, out_rd); end
      tick();
    end
    out_ready = 1'b1; #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_release got %b exp 1", in_ready); end
    tick(); in_valid = 1'b0;
    vectors++; if (out_result !== 32'd9 || out_rd !== 5'd4) begin miscompares++; $display("FAIL bp_next got r=%h rd=%0d exp r=9 rd=4", out_result, out_rd); end
    tick();
    issue(OPC_OP_IMM, F3_ADD, 7'd0, 5'd3, 5'd0, 5'd0, 32'd0, 1'b1, 32'd0);
    vectors++; if (out_result !== 32'd9) begin miscompares++; $display("FAIL bp_rf_x3 got %h exp 9", out_result); end
    issue(OPC_OP_IMM, F3_ADD, 7'd0, 5'd4, 5'd0, 5'd0, 32'd0, 1'b1, 32'd0);
    vectors++; if (out_result !== 32'd9) begin miscompares++; $display("FAIL bp_rf_x4 got %h exp 9", out_result); end
  endtask

  task automatic test_signed();
    issue(OPC_OP_IMM, F3_ADD, 7'd0, 5'd0, 5'd0, 5'd5, 32'hFFFF_FFFF, 1'b1, 32'd0);
    issue(OPC_OP_IMM, F3_ADD, 7'd0, 5'd0, 5'd0, 5'd6, 32'd1, 1'b1, 32'd0);
    issue(OPC_OP, F3_SLT, 7'd0, 5'd5, 5'd6, 5'd7, 32'd0, 1'b0, 32'd0);
    vectors++; if (out_result !== 32'd1) begin miscompares++; $display("FAIL slt got %h exp 1", out_result); end
    issue(OPC_OP, F3_SLTU, 7'd0, 5'd5, 5'd6, 5'd7, 32'd0, 1'b0, 32'd0);
    vectors++; if (out_result !== 32'd0) begin miscompares++; $display("FAIL sltu got %h exp 0", out_result); end
    issue(OPC_OP_IMM, F3_SR, 7'h20, 5'd5, 5'd0, 5'd7, 32'h404, 1'b1, 32'd0);
    vectors++; if (out_result !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL srai got %h exp ffffffff", out_result); end
    issue(OPC_OP_IMM, F3_SR, 7'h00, 5'd5, 5'd0, 5'd7, 32'd4, 1'b1, 32'd0);
    vectors++; if (out_result !== 32'h0FFF_FFFF) begin miscompares++; $display("FAIL srli got %h exp 0fffffff", out_result); end
    issue(OPC_OP, F3_ADD, 7'h20, 5'd6, 5'd5, 5'd7, 32'd0, 1'b0, 32'd0);
    vectors++; if (out_result !== 32'd2) begin miscompares++; $display("FAIL sub got %h exp 2", out_result); end
    issue(OPC_OP, F3_ADD, 7'h00, 5'd5, 5'd6, 5'd7, 32'd0, 1'b0, 32'd0);
    vectors++; if (out_result !== 32'd0) begin miscompares++; $display("FAIL add_wrap got %h exp 0", out_result); end
    issue(OPC_BRANCH, F3_BLT, 7'd0, 5'd5, 5'd6, 5'd0, 32'h10, 1'b0, 32'h40);
    vectors++; if (out_branch !== 1'b1 || out_target !== 32'h50 || out_we !== 1'b0) begin miscompares++; $display("FAIL blt got b=%b t=%h we=%b exp b=1 t=50 we=0", out_branch, out_target, out_we); end
    issue(OPC_BRANCH, F3_BLTU, 7'd0, 5'd5, 5'd6, 5'd0, 32'h10, 1'b0, 32'h40);
    vectors++; if (out_branch !== 1'b0) begin miscompares++; $display("FAIL bltu got %b exp 0", out_branch); end
    issue(OPC_BRANCH, F3_BGEU, 7'd0, 5'd5, 5'd6, 5'd0, 32'h10, 1'b0, 32'h40);
    vectors++; if (out_branch !== 1'b1) begin miscompares++; $display("FAIL bgeu got %b exp 1", out_branch); end
  endtask

  task automatic test_control();
    issue(OPC_JAL, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'h20, 1'b1, 32'h100);
    vectors++; if (out_target !== 32'h120 || out_result !== 32'h104 || out_branch !== 1'b1 || out_we !== 1'b1) begin miscompares++; $display("FAIL jal got t=%h r=%h b=%b we=%b exp t=120 r=104 b=1 we=1", out_target, out_result, out_branch, out_we); end
    issue(OPC_OP_IMM, F3_ADD, 7'd0, 5'd0, 5'd0, 5'd8, 32'h201, 1'b1, 32'd0);
    issue(OPC_JALR, 3'd0, 7'd0, 5'd8, 5'd0, 5'd1, 32'd0, 1'b1, 32'h100);
    vectors++; if (out_target !== 32'h200 || out_result !== 32'h104 || out_branch !== 1'b1) begin miscompares++; $display("FAIL jalr got t=%h r=%h b=%b exp t=200 r=104 b=1", out_target, out_result, out_branch); end
    issue(OPC_LUI, 3'd0, 7'd0, 5'd0, 5'd0, 5'd2, 32'h12345, 1'b1, 32'h100);
    vectors++; if (out_result !== 32'h1234_5000) begin miscompares++; $display("FAIL lui got %h exp 12345000", out_result); end
    issue(OPC_AUIPC, 3'd0, 7'd0, 5'd0, 5'd0, 5'd2, 32'h1, 1'b1, 32'h100);
    vectors++; if (out_result !== 32'h1100) begin miscompares++; $display("FAIL auipc got %h exp 1100", out_result); end
  endtask

  task automatic test_mem_illegal();
    issue(OPC_LUI, 3'd0, 7'd0, 5'd0, 5'd0, 5'd9, 32'h1, 1'b1, 32'd0);
    issue(OPC_OP_IMM, F3_ADD, 7'd0, 5'd0, 5'd0, 5'd10, 32'hAB, 1'b1, 32'd0);
    issue(OPC_OP_IMM, F3_ADD, 7'd0, 5'd0, 5'd0, 5'd11, 32'h55, 1'b1, 32'd0);
    issue(OPC_STORE, 3'b010, 7'd0, 5'd9, 5'd10, 5'd0, 32'hFFFF_FFFC, 1'b1, 32'd0);
    vectors++; if (out_mem_wr !== 1'b1 || out_mem_addr !== 32'hFFC || out_store_data !== 32'hAB || out_we !== 1'b0) begin miscompares++; $display("FAIL sw got wr=%b a=%h d=%h we=%b exp wr=1 a=ffc d=ab we=0", out_mem_wr, out_mem_addr, out_store_data, out_we); end
    issue(OPC_LOAD, 3'b010, 7'd0, 5'd9, 5'd0, 5'd12, 32'h8, 1'b1, 32'd0);
    vectors++; if (out_mem_rd !== 1'b1 || out_mem_addr !== 32'h1008 || out_result !== 32'd0 || out_we !== 1'b1) begin miscompares++; $display("FAIL lw got rd=%b a=%h r=%h we=%b exp rd=1 a=1008 r=0 we=1", out_mem_rd, out_mem_addr, out_result, out_we); end
    issue(7'h7F, 3'd0, 7'd0, 5'd9, 5'd10, 5'd11, 32'h4, 1'b1, 32'd0);
    vectors++; if (out_illegal !== 1'b1 || out_we !== 1'b0 || out_result !== 32'd0 || out_mem_wr !== 1'b0) begin miscompares++; $display("FAIL illegal got il=%b we=%b r=%h wr=%b exp il=1 we=0 r=0 wr=0", out_illegal, out_we, out_result, out_mem_wr); end
    tick();
    issue(OPC_OP_IMM, F3_ADD, 7'd0, 5'd11, 5'd0, 5'd0, 32'd0, 1'b1, 32'd0);
    vectors++; if (out_result !== 32'h55) begin miscompares++; $display("FAIL illegal_nowrite got %h exp 55", out_result); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_forward();
    test_backpressure();
    test_signed();
    test_control();
    test_mem_illegal();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
